// File: rtl/tl_pkg.sv
// Shared TileLink-UH encodings, FSM state type and helpers for the SRAM slave.
// The atomic helper is only referenced when TL_UH_SRAM_ATOMIC_EN is defined.
package tl_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGIC       = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;

  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;

  localparam logic [2:0] AR_MIN  = 3'd0;
  localparam logic [2:0] AR_MAX  = 3'd1;
  localparam logic [2:0] AR_MINU = 3'd2;
  localparam logic [2:0] AR_MAXU = 3'd3;
  localparam logic [2:0] AR_ADD  = 3'd4;

  localparam logic [2:0] LG_XOR  = 3'd0;
  localparam logic [2:0] LG_OR   = 3'd1;
  localparam logic [2:0] LG_AND  = 3'd2;
  localparam logic [2:0] LG_SWAP = 3'd3;

  // Wide enough for the largest encodable a_size (15 -> 8192 beats).
  localparam int unsigned BEAT_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ACK,
    ST_ATOM_RD,
    ST_ATOM_WR
  } state_e;

  function automatic logic [BEAT_W-1:0] beats_from_size(input logic [3:0] size);
    if (size <= 4'd2) return BEAT_W'(1);
    return BEAT_W'(1) << (size - 4'd2);
  endfunction

  function automatic logic [31:0] atomic_alu(input logic arith, input logic [2:0] param,
                                             input logic [31:0] old, input logic [31:0] arg);
    if (arith) begin
      case (param)
        AR_MIN:  return ($signed(arg) < $signed(old)) ? arg : old;
        AR_MAX:  return ($signed(arg) > $signed(old)) ? arg : old;
        AR_MINU: return (arg < old) ? arg : old;
        AR_MAXU: return (arg > old) ? arg : old;
        default: return old + arg;
      endcase
    end
    case (param)
      LG_XOR:  return old ^ arg;
      LG_OR:   return old | arg;
      LG_AND:  return old & arg;
      default: return arg;
    endcase
  endfunction

endpackage

// File: rtl/tl_sram_array.sv
// Single-port word-wide SRAM with per-byte write enables and a registered
// read port that holds its last value while read enable is low.
module tl_sram_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/tl_uh_sram_slave.sv
// TileLink-UH slave (Get/PutFull/PutPartial, single and multi-beat) over an on-chip SRAM.
// Define TL_UH_SRAM_ATOMIC_EN to add single-beat ArithmeticData/LogicalData support.
module tl_uh_sram_slave
  import tl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned MAX_SIZE    = 6
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_ni,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        a_corrupt,
  input  logic        a_valid,
  output logic        a_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt,
  output logic        d_valid,
  input  logic        d_ready
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  state_e            state;
  logic [BEAT_W-1:0] beats_left;
  logic [AW-1:0]     idx;
  logic              denied_r;
  logic              data_sel;

  logic              mem_re;
  logic [3:0]        mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              a_fire, is_put, is_get, op_ok, misaligned, range_ok, req_denied, advance;
  logic [32:0]       req_end;
  logic [BEAT_W-1:0] req_beats;

  assign a_fire     = a_valid && a_ready;
  assign is_put     = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
  assign is_get     = (a_opcode == A_GET);
  assign req_end    = {1'b0, a_address} + ((33'd1 << a_size) - 33'd1);
  assign misaligned = (a_address & ((32'd1 << a_size) - 32'd1)) != '0;
  assign range_ok   = (a_address >= BASE_ADDR) && (req_end < END_ADDR);

`ifdef TL_UH_SRAM_ATOMIC_EN
  logic        atom_ok, atom_arith;
  logic [2:0]  atom_param;
  logic [3:0]  atom_mask;
  logic [31:0] atom_data;

  assign op_ok = is_put || is_get ||
                 ((a_size <= 4'd2) && (((a_opcode == A_ARITH) && (a_param <= AR_ADD)) ||
                                       ((a_opcode == A_LOGIC) && (a_param <= LG_SWAP))));
  assign atom_ok = ((a_opcode == A_ARITH) || (a_opcode == A_LOGIC)) && !req_denied;

  always_ff @(posedge cpu_clk_i) begin
    if ((state == ST_IDLE) && a_fire && atom_ok) begin
      atom_arith <= (a_opcode == A_ARITH);
      atom_param <= a_param;
      atom_mask  <= a_mask;
      atom_data  <= a_data;
    end
  end
`else
  logic unused_param;
  assign op_ok        = is_put || is_get;
  assign unused_param = ^a_param;
`endif

  assign req_denied = misaligned || (32'(a_size) > MAX_SIZE) || !range_ok || !op_ok;
  // Anything that is neither Get nor Put answers with exactly one data beat.
  assign req_beats  = (is_put || is_get) ? beats_from_size(a_size) : BEAT_W'(1);
  assign advance    = (beats_left != '0) && (!d_valid || d_ready);

  assign d_param = '0;
  assign d_data  = (d_valid && data_sel) ? mem_rdata : '0;

  always_comb begin
    mem_addr  = idx;
    mem_re    = 1'b0;
    mem_we    = '0;
    mem_wdata = a_data;
    case (state)
      ST_IDLE: begin
        if (a_fire && is_put && !req_denied) begin
          mem_addr = a_address[AW+1:2];
          mem_we   = a_corrupt ? 4'h0 : a_mask;
        end
      end
      ST_WRITE: if (a_fire && !denied_r && !a_corrupt) mem_we = a_mask;
      ST_READ:  mem_re = advance && !denied_r;
`ifdef TL_UH_SRAM_ATOMIC_EN
      ST_ATOM_RD: mem_re = 1'b1;
      ST_ATOM_WR: begin
        mem_we    = atom_mask;
        mem_wdata = atomic_alu(atom_arith, atom_param, mem_rdata, atom_data);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      state      <= ST_IDLE;
      beats_left <= '0;
      idx        <= '0;
      denied_r   <= 1'b0;
      data_sel   <= 1'b0;
      a_ready    <= 1'b0;
      d_valid    <= 1'b0;
      d_opcode   <= '0;
      d_size     <= '0;
      d_denied   <= 1'b0;
      d_corrupt  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          a_ready <= 1'b1;
          if (a_fire) begin
            idx      <= a_address[AW+1:2];
            d_size   <= a_size;
            denied_r <= req_denied;
            if (is_put) begin
              if (req_beats == BEAT_W'(1)) begin
                state     <= ST_ACK;
                a_ready   <= 1'b0;
                d_valid   <= 1'b1;
                d_opcode  <= D_ACK;
                d_denied  <= req_denied;
                d_corrupt <= 1'b0;
                data_sel  <= 1'b0;
              end else begin
                state      <= ST_WRITE;
                idx        <= a_address[AW+1:2] + AW'(1);
                beats_left <= req_beats - BEAT_W'(1);
              end
            end
`ifdef TL_UH_SRAM_ATOMIC_EN
            else if (atom_ok) begin
              state   <= ST_ATOM_RD;
              a_ready <= 1'b0;
            end
`endif
            else begin
              state      <= ST_READ;
              a_ready    <= 1'b0;
              beats_left <= req_beats;
              d_opcode   <= D_ACK_DATA;
              d_denied   <= req_denied;
              d_corrupt  <= req_denied;
              data_sel   <= !req_denied;
            end
          end
        end
        ST_READ: begin
          // SRAM output is the D data register; it only advances when the slot frees.
          if (advance) begin
            beats_left <= beats_left - BEAT_W'(1);
            idx        <= idx + AW'(1);
            d_valid    <= 1'b1;
          end else if (d_valid && d_ready) begin
            d_valid <= 1'b0;
            state   <= ST_IDLE;
            a_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (a_fire) begin
            idx        <= idx + AW'(1);
            beats_left <= beats_left - BEAT_W'(1);
            if (beats_left == BEAT_W'(1)) begin
              state     <= ST_ACK;
              a_ready   <= 1'b0;
              d_valid   <= 1'b1;
              d_opcode  <= D_ACK;
              d_denied  <= denied_r;
              d_corrupt <= 1'b0;
              data_sel  <= 1'b0;
            end
          end
        end
        ST_ACK: begin
          if (d_ready) begin
            d_valid <= 1'b0;
            state   <= ST_IDLE;
            a_ready <= 1'b1;
          end
        end
        ST_ATOM_RD: state <= ST_ATOM_WR;
        ST_ATOM_WR: begin
          state     <= ST_ACK;
          d_valid   <= 1'b1;
          d_opcode  <= D_ACK_DATA;
          d_denied  <= 1'b0;
          d_corrupt <= 1'b0;
          data_sel  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tl_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk  (cpu_clk_i),
    .re   (mem_re),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

endmodule
